// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and sizing for the FIFO stream reader and its output buffer.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    STOP = 2'd1,
    IDLE = 2'd2
  } reader_state_t;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_reader_skid_buf.sv
// Two-entry FIFO-ordered buffer; head_data always presents the oldest entry.
module fifo_reader_skid_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [OCC_W-1:0]     occ,
  output logic [DATA_BITS-1:0] head_data
);

  logic [OCC_W-1:0]     r_occ;
  logic [DATA_BITS-1:0] r_slot0;
  logic [DATA_BITS-1:0] r_slot1;

  // The head slot only changes on a pop or when a word lands in an empty buffer,
  // which keeps head_data stable while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ   <= '0;
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_occ == '0) r_slot0 <= push_data;
          else             r_slot1 <= push_data;
          r_occ <= r_occ + OCC_W'(1);
        end
        2'b01: begin
          r_slot0 <= r_slot1;
          r_occ   <= r_occ - OCC_W'(1);
        end
        2'b11: begin
          if (r_occ == OCC_W'(1)) begin
            r_slot0 <= push_data;
          end else begin
            r_slot0 <= r_slot1;
            r_slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ       = r_occ;
  assign head_data = r_slot0;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains an async FIFO read port into a valid/ready stream with a two-word buffer.
// Optional FIFO_STREAM_READER_CNT_EN adds a 32-bit delivered-word counter output.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 read,
  input  logic                 empty,
  input  logic [DATA_BITS-1:0] output_data,
  output logic                 m_valid,
  output logic [DATA_BITS-1:0] m_data,
  input  logic                 m_ready,
  output logic                 idle
`ifdef FIFO_STREAM_READER_CNT_EN
  ,
  output logic [31:0]          word_count
`endif
);

  reader_state_t        r_state;
  reader_state_t        w_state_next;
  logic                 r_inflight;
  logic [OCC_W-1:0]     w_occ;
  logic [OCC_W:0]       w_pending;
  logic                 w_pop;
  logic                 w_read;
  logic [DATA_BITS-1:0] w_head;

  fifo_reader_skid_buf #(
    .DATA_BITS(DATA_BITS)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (r_inflight),
    .push_data(output_data),
    .pop      (w_pop),
    .occ      (w_occ),
    .head_data(w_head)
  );

  assign m_valid = (w_occ != '0);
  assign m_data  = w_head;
  assign w_pop   = m_valid & m_ready;

  // Credit: buffered plus in-flight words may never exceed the buffer depth,
  // unless a pop this cycle frees a slot for the word being requested.
  assign w_pending = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight};
  assign w_read    = ~reset & enable & ~empty &
                     ((w_pending < (OCC_W+1)'(BUF_DEPTH)) | w_pop);
  assign read      = w_read;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_state    <= IDLE;
    end else begin
      r_inflight <= w_read;
      r_state    <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_next = RUN;
      RUN:     if (!enable) w_state_next = STOP;
      STOP: begin
        if (enable)                           w_state_next = RUN;
        else if (!r_inflight && w_occ == '0)  w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign idle = (r_state == IDLE);

`ifdef FIFO_STREAM_READER_CNT_EN
  logic [31:0] r_word_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_word_count <= 32'd0;
    else if (w_pop) r_word_count <= r_word_count + 32'd1;
  end

  assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a behavioural FIFO read port.
module tb_fifo_stream_reader;

  localparam int DATA_BITS = 10;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 enable = 1'b0;
  logic                 m_ready = 1'b0;
  logic                 empty;
  logic                 read;
  logic                 m_valid;
  logic                 idle;
  logic [DATA_BITS-1:0] output_data = '0;
  logic [DATA_BITS-1:0] m_data;
`ifdef FIFO_STREAM_READER_CNT_EN
  logic [31:0]          word_count;
`endif

  logic [DATA_BITS-1:0] fifo_q[$];
  logic [DATA_BITS-1:0] wr_q[$];
  logic [DATA_BITS-1:0] exp_q[$];
  logic [DATA_BITS-1:0] exp_w;
  logic [DATA_BITS-1:0] prev_data = '0;
  logic                 prev_hold = 1'b0;
  int fifo_cnt = 0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int n_reads = 0, n_pops = 0, rd_gaps = 0, pop_gaps = 0;
  int first_rd = 0, first_pop = 0, last_rd = 0, last_pop = 0;
  int rd_empty = 0;
  int idle_cyc = 0;

  always #5 clk = ~clk;

  assign empty = (fifo_cnt == 0);

  fifo_stream_reader #(
    .DATA_BITS(DATA_BITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .read       (read),
    .empty      (empty),
    .output_data(output_data),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .idle       (idle)
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    .word_count (word_count)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO read side: data appears the cycle after read; writes land at the next edge.
  always @(posedge clk) begin
    if (reset) begin
      fifo_q.delete();
      wr_q.delete();
      fifo_cnt    <= 0;
      output_data <= '0;
    end else begin
      if (read) output_data <= fifo_q.pop_front();
      while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
      fifo_cnt <= fifo_q.size();
    end
  end

  // Monitor: read statistics, hold stability and in-order delivery.
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (read) begin
        if (empty) rd_empty++;
        if (n_reads > 0 && cyc != last_rd + 1) rd_gaps++;
        if (n_reads == 0) first_rd = cyc;
        last_rd = cyc;
        n_reads++;
      end
      if (prev_hold) begin
        checks++;
        if (!m_valid || m_data !== prev_data) begin
          errors++;
          $display("FAIL hold_stable: m_valid=%0b m_data=0x%03h, required m_valid=1 m_data=0x%03h",
                   m_valid, m_data, prev_data);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got 0x%03h, required no word", m_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (m_data !== exp_w) begin
            errors++;
            $display("FAIL word_order: got 0x%03h, required 0x%03h", m_data, exp_w);
          end else begin
            $display("pop  0x%03h cycle %0d", m_data, cyc);
          end
        end
        if (n_pops > 0 && cyc != last_pop + 1) pop_gaps++;
        if (n_pops == 0) first_pop = cyc;
        last_pop = cyc;
        n_pops++;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_BITS-1:0] w);
    wr_q.push_back(w);
    exp_q.push_back(w);
    $display("push 0x%03h", w);
  endtask

  task automatic clr_stats();
    n_reads = 0; n_pops = 0; rd_gaps = 0; pop_gaps = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end else begin
      $display("check %s = 0x%0h", name, act);
    end
  endtask

  task automatic wait_pops(input int target, input int budget);
    int k;
    k = 0;
    while (n_pops < target && k < budget) begin
      step(1);
      k++;
    end
    if (n_pops < target) begin
      checks++;
      errors++;
      $display("FAIL pop_timeout: got %0d pops, required %0d", n_pops, target);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!idle && k < budget) begin
      step(1);
      k++;
    end
    idle_cyc = cyc;
  endtask

  initial begin
    // Reset values
    step(2);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    reset = 1'b0;
    step(1);

    // Streaming from a preloaded FIFO
    for (int i = 1; i <= 8; i++) push_word(DATA_BITS'(i));
    step(2);
    clr_stats();
    enable  = 1'b1;
    m_ready = 1'b1;
    step(1);
    chk("run_idle", 32'(idle), 32'd0);
    wait_pops(8, 30);
    chk("stream_reads", 32'(n_reads), 32'd8);
    chk("stream_read_gaps", 32'(rd_gaps), 32'd0);
    chk("stream_pop_gaps", 32'(pop_gaps), 32'd0);
    chk("stream_latency", 32'(first_pop - first_rd), 32'd2);

    // Backpressure
    m_ready = 1'b0;
    clr_stats();
    for (int i = 1; i <= 5; i++) push_word(DATA_BITS'(16 + i));
    step(8);
    chk("bp_reads", 32'(n_reads), 32'd2);
    chk("bp_m_valid", 32'(m_valid), 32'd1);
    chk("bp_m_data", 32'(m_data), 32'h011);
    m_ready = 1'b1;
    wait_pops(5, 30);
    chk("bp_reads_total", 32'(n_reads), 32'd5);
    chk("bp_pop_gaps", 32'(pop_gaps), 32'd0);

    // Single word through an otherwise empty FIFO
    clr_stats();
    step(3);
    push_word(10'h3FF);
    step(8);
    chk("single_reads", 32'(n_reads), 32'd1);
    chk("single_pops", 32'(n_pops), 32'd1);

    // Stop mid-stream, then resume
    enable = 1'b0;
    wait_idle(20);
    chk("stop_idle_pre", 32'(idle), 32'd1);
    clr_stats();
    for (int i = 1; i <= 4; i++) push_word(DATA_BITS'(32 + i));
    step(3);
    chk("disabled_reads", 32'(n_reads), 32'd0);
    enable = 1'b1;
    step(3);
    enable = 1'b0;
    wait_idle(20);
    chk("stop_reads", 32'(n_reads), 32'd3);
    chk("stop_pops", 32'(n_pops), 32'd3);
    chk("stop_idle", 32'(idle), 32'd1);
    chk("idle_after_pop", 32'(idle_cyc > last_pop), 32'd1);
    enable = 1'b1;
    wait_pops(4, 20);
    chk("resume_idle", 32'(idle), 32'd0);

    // Reset with a full buffer
    m_ready = 1'b0;
    clr_stats();
    for (int i = 1; i <= 3; i++) push_word(DATA_BITS'(48 + i));
    step(8);
    chk("prerst_reads", 32'(n_reads), 32'd2);
    chk("prerst_m_valid", 32'(m_valid), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_read", 32'(read), 32'd0);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_m_data", 32'(m_data), 32'd0);
    chk("midrst_idle", 32'(idle), 32'd1);
    step(2);
    reset   = 1'b0;
    m_ready = 1'b1;
    clr_stats();
    step(1);
    for (int i = 1; i <= 3; i++) push_word(DATA_BITS'(64 + i));
    wait_pops(3, 30);
    chk("postrst_reads", 32'(n_reads), 32'd3);
    chk("postrst_pop_gaps", 32'(pop_gaps), 32'd0);

`ifdef FIFO_STREAM_READER_CNT_EN
    // Delivered-word counter and its wrap
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    clr_stats();
    step(1);
    for (int i = 0; i < 10; i++) push_word(DATA_BITS'(80 + i));
    wait_pops(10, 40);
    step(1);
    chk("count_ten", word_count, 32'd10);
    force dut.r_word_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_word_count;
    clr_stats();
    push_word(10'h0AA);
    wait_pops(1, 20);
    step(1);
    chk("count_wrap", word_count, 32'd0);
`endif

    step(4);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("read_while_empty", 32'(rd_empty), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
